// File: rtl/steer_arbiter_pkg.sv
// Shared encodings for the steering arbiter: operating modes, step directions
// and the power-on servo position.
package steer_arbiter_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_MANUAL = 2'b10
  } mode_t;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  localparam logic [7:0] DEFAULT_POS_INIT = 8'd128;

endpackage

// File: rtl/steer_arbiter_hold_timer.sv
// Manual lock-out down-counter: reload on any override, count down on request.
// 'expired' marks the final hold cycle so the mode flips exactly on time.
module hold_timer #(
  parameter logic [31:0] HOLD_CYCLES = 32'd27_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [31:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= HOLD_CYCLES;
    end else if (dec && (count != '0)) begin
      count <= count - 32'd1;
    end
  end

  // A count of 1 being consumed this cycle means the hold ends on the next edge.
  assign expired = (count <= 32'd1);

endmodule

// File: rtl/steer_arbiter.sv
// Arbitrates override and tracker steering requests into a single clamped
// servo position, emitted through a valid/ready handshake.
//
// state        | meaning
// MODE_IDLE    | tracking disabled, overrides still accepted
// MODE_AUTO    | tracker requests applied when the output slot is free
// MODE_MANUAL  | override hold-off; tracker requests dropped until the timer ends
module steer_arbiter
  import steer_arbiter_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES  = 32'd27_000_000,
  parameter logic [7:0]  POS_INIT     = DEFAULT_POS_INIT,
  parameter logic [7:0]  POS_MIN      = 8'd0,
  parameter logic [7:0]  POS_MAX      = 8'd255,
  parameter logic [7:0]  TRK_MAX_STEP = 8'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ovr_dir,
  input  logic [7:0] ovr_val,
  input  logic       ovr_done,
  input  logic       trk_dir,
  input  logic [7:0] trk_val,
  input  logic       trk_valid,
  input  logic       enable_auto,
  input  logic       pos_ready,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic [1:0] mode,
  output logic       trk_drop
);

  mode_t       mode_q;
  mode_t       mode_next;
  logic        pend_flag;
  logic        pend_dir;
  logic [7:0]  pend_val;

  logic        slot_free;
  logic        ovr_req;
  logic        ovr_have;
  logic        ovr_take;
  logic        trk_take;
  logic        upd;
  logic        step_dir;
  logic [7:0]  step_val;
  logic [7:0]  trk_step;
  logic signed [9:0] sum;
  logic [7:0]  pos_next;
  logic        timer_dec;
  logic        timer_expired;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (ovr_done),
    .dec     (timer_dec),
    .expired (timer_expired)
  );

  // Request selection and clamped position arithmetic.
  always_comb begin
    slot_free = !pos_valid || pos_ready;
    ovr_req   = ovr_done && (ovr_val != 8'd0);
    ovr_have  = ovr_req || (!ovr_done && pend_flag);
    ovr_take  = ovr_have && slot_free;
    trk_take  = trk_valid && (mode_q == MODE_AUTO) && !ovr_done && slot_free;
    upd       = ovr_take || trk_take;
    trk_step  = (trk_val > TRK_MAX_STEP) ? TRK_MAX_STEP : trk_val;

    step_dir = trk_dir;
    step_val = trk_step;
    if (ovr_take) begin
      step_dir = ovr_req ? ovr_dir : pend_dir;
      step_val = ovr_req ? ovr_val : pend_val;
    end

    if (step_dir == DIR_DEC) begin
      sum = $signed({2'b00, pos}) - $signed({2'b00, step_val});
    end else begin
      sum = $signed({2'b00, pos}) + $signed({2'b00, step_val});
    end

    pos_next = sum[7:0];
    if (sum < $signed({2'b00, POS_MIN})) begin
      pos_next = POS_MIN;
    end else if (sum > $signed({2'b00, POS_MAX})) begin
      pos_next = POS_MAX;
    end
  end

  always_comb begin
    mode_next = mode_q;
    timer_dec = 1'b0;
    if (ovr_done) begin
      mode_next = MODE_MANUAL;
    end else begin
      case (mode_q)
        MODE_MANUAL: begin
          // The hold is frozen while an override is still waiting for the slot.
          if (!pend_flag) begin
            timer_dec = 1'b1;
            if (timer_expired) begin
              mode_next = enable_auto ? MODE_AUTO : MODE_IDLE;
            end
          end
        end
        MODE_AUTO: begin
          if (!enable_auto) mode_next = MODE_IDLE;
        end
        default: begin
          if (enable_auto) mode_next = MODE_AUTO;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= MODE_IDLE;
      pos       <= POS_INIT;
      pos_valid <= 1'b0;
      trk_drop  <= 1'b0;
      pend_flag <= 1'b0;
      pend_dir  <= DIR_INC;
      pend_val  <= 8'd0;
    end else begin
      mode_q   <= mode_next;
      trk_drop <= trk_valid && !trk_take;

      if (upd) begin
        pos       <= pos_next;
        pos_valid <= 1'b1;
      end else if (pos_ready) begin
        pos_valid <= 1'b0;
      end

      if (ovr_done) begin
        pend_flag <= ovr_req && !slot_free;
        pend_dir  <= ovr_dir;
        pend_val  <= ovr_val;
      end else if (slot_free) begin
        pend_flag <= 1'b0;
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_steer_arbiter.sv
// Directed bench for steer_arbiter: a cycle-level reference model checked every
// cycle, plus hand-computed expectations along the scenario.
module tb_steer_arbiter;

  localparam int HOLD = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ovr_dir = 1'b0;
  logic [7:0] ovr_val = 8'd0;
  logic       ovr_done = 1'b0;
  logic       trk_dir = 1'b0;
  logic [7:0] trk_val = 8'd0;
  logic       trk_valid = 1'b0;
  logic       enable_auto = 1'b0;
  logic       pos_ready = 1'b1;
  logic [7:0] pos;
  logic       pos_valid;
  logic [1:0] mode;
  logic       trk_drop;

  int passed = 0;
  int total = 0;

  steer_arbiter #(.HOLD_CYCLES(32'(HOLD))) dut (
    .clock(clock), .reset(reset),
    .ovr_dir(ovr_dir), .ovr_val(ovr_val), .ovr_done(ovr_done),
    .trk_dir(trk_dir), .trk_val(trk_val), .trk_valid(trk_valid),
    .enable_auto(enable_auto), .pos_ready(pos_ready),
    .pos(pos), .pos_valid(pos_valid), .mode(mode), .trk_drop(trk_drop)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0 idle, 1 auto, 2 manual; hold expressed as a deadline cycle.
  int     m_pos = 128;
  bit     m_valid = 0;
  int     m_mode = 0;
  bit     m_drop = 0;
  bit     m_pf = 0;
  bit     m_pd = 0;
  int     m_pv = 0;
  longint m_deadline = 0;
  longint cyc = 0;
  bit     armed = 0;

  always @(posedge clock) begin
    bit free, req, have, trk_ok, d, applied;
    int s, p;
    if (reset) begin
      m_pos = 128; m_valid = 0; m_mode = 0; m_drop = 0; m_pf = 0;
      armed = 1;
    end else begin
      free    = !m_valid || pos_ready;
      req     = ovr_done && (ovr_val != 0);
      have    = req || (!ovr_done && m_pf);
      trk_ok  = trk_valid && (m_mode == 1) && !ovr_done && free;
      applied = 0;
      d = 0; s = 0;
      if (free && have) begin
        d = req ? ovr_dir : m_pd;
        s = req ? int'(ovr_val) : m_pv;
        applied = 1;
      end else if (trk_ok) begin
        d = trk_dir;
        s = (trk_val > 4) ? 4 : int'(trk_val);
        applied = 1;
      end
      if (applied) begin
        p = d ? m_pos - s : m_pos + s;
        if (p < 0) p = 0;
        if (p > 255) p = 255;
        m_pos = p;
      end
      m_drop = trk_valid && !trk_ok;
      if (ovr_done) begin
        m_mode = 2;
        m_deadline = cyc + 1 + HOLD;
      end else if (m_mode == 2) begin
        if (m_pf) m_deadline = m_deadline + 1;
        if (cyc + 1 >= m_deadline) m_mode = enable_auto ? 1 : 0;
      end else if (m_mode == 1) begin
        if (!enable_auto) m_mode = 0;
      end else begin
        if (enable_auto) m_mode = 1;
      end
      if (ovr_done) begin
        m_pf = req && !free; m_pd = ovr_dir; m_pv = int'(ovr_val);
      end else if (free) begin
        m_pf = 0;
      end
      m_valid = applied ? 1'b1 : (pos_ready ? 1'b0 : m_valid);
    end
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (armed) begin
      total++;
      if (int'(pos) == m_pos && pos_valid == m_valid && int'(mode) == m_mode && trk_drop == m_drop)
        passed++;
      else
        $display("FAIL model cyc=%0d got pos=%0d valid=%0b mode=%0d drop=%0b want pos=%0d valid=%0b mode=%0d drop=%0b",
                 cyc, pos, pos_valid, mode, trk_drop, m_pos, m_valid, m_mode, m_drop);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got %0d want %0d", name, act, exp);
  endtask

  task automatic step(input logic od, input logic [7:0] ov, input logic odone,
                      input logic td, input logic [7:0] tv, input logic tvalid,
                      input logic rdy);
    ovr_dir = od; ovr_val = ov; ovr_done = odone;
    trk_dir = td; trk_val = tv; trk_valid = tvalid; pos_ready = rdy;
    @(negedge clock);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    chk("reset_pos", pos, 128);
    chk("reset_valid", pos_valid, 0);
    chk("reset_mode", mode, 0);

    step(0, 8'd2, 1, 0, 0, 0, 1);
    chk("ovr_pos", pos, 130);
    chk("ovr_valid", pos_valid, 1);
    chk("ovr_mode", mode, 2);
    idle(1);
    chk("ovr_valid_pulse", pos_valid, 0);

    step(0, 8'd124, 1, 0, 0, 0, 1);
    step(0, 8'd5, 1, 0, 0, 0, 1);
    chk("clamp_hi", pos, 255);
    chk("clamp_hi_valid", pos_valid, 1);
    step(1, 8'd254, 1, 0, 0, 0, 1);
    step(1, 8'd5, 1, 0, 0, 0, 1);
    chk("clamp_lo", pos, 0);
    chk("clamp_lo_valid", pos_valid, 1);

    enable_auto = 1;
    step(0, 8'd10, 1, 0, 0, 0, 1);
    repeat (9) idle(1);
    chk("hold_still_manual", mode, 2);
    idle(1);
    chk("hold_to_auto", mode, 1);
    step(0, 0, 0, 0, 8'd9, 1, 1);
    chk("trk_clip", pos, 14);
    idle(1);

    step(0, 8'd1, 1, 0, 0, 0, 0);
    step(0, 8'd3, 1, 0, 0, 0, 0);
    idle(0);
    step(1, 8'd7, 1, 0, 0, 0, 0);
    idle(0);
    idle(0);
    chk("bp_stable_pos", pos, 15);
    chk("bp_stable_valid", pos_valid, 1);
    idle(1);
    chk("bp_second_ovr", pos, 8);
    idle(1);

    step(0, 8'd6, 1, 0, 0, 0, 0);
    step(0, 8'd4, 1, 0, 0, 0, 0);
    step(0, 8'd0, 1, 0, 0, 0, 0);
    idle(1);
    chk("stop_pos", pos, 14);
    chk("stop_valid", pos_valid, 0);

    repeat (12) idle(1);
    chk("auto_again", mode, 1);
    step(0, 0, 0, 0, 8'd2, 1, 0);
    step(0, 0, 0, 0, 8'd2, 1, 0);
    chk("busy_drop", trk_drop, 1);
    chk("busy_pos", pos, 16);
    idle(1);

    step(0, 8'd2, 1, 0, 8'd3, 1, 1);
    chk("simul_pos", pos, 18);
    chk("simul_drop", trk_drop, 1);
    chk("simul_mode", mode, 2);

    step(0, 8'd1, 1, 0, 0, 0, 0);
    reset = 1;
    idle(0);
    chk("rst_pos", pos, 128);
    chk("rst_valid", pos_valid, 0);
    chk("rst_mode", mode, 0);
    reset = 0;
    idle(0);
    chk("rst_exit_valid", pos_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
